// File: rtl/eject_collector_if.sv
// Bundle of the six router ejection ports and the local output port of the
// ejection collector. The slave modport is the collector's view; the master
// modport is the view of the environment (router plus consuming application).
// The drop_count signal exists only when EJECT_COLLECTOR_DROP_CNT_EN is defined.
interface eject_collector_if #(
    parameter int FLIT_SIZE = 82
);
    logic [FLIT_SIZE-1:0] eject_xpos;
    logic [FLIT_SIZE-1:0] eject_ypos;
    logic [FLIT_SIZE-1:0] eject_zpos;
    logic [FLIT_SIZE-1:0] eject_xneg;
    logic [FLIT_SIZE-1:0] eject_yneg;
    logic [FLIT_SIZE-1:0] eject_zneg;
    logic                 eject_xpos_valid;
    logic                 eject_ypos_valid;
    logic                 eject_zpos_valid;
    logic                 eject_xneg_valid;
    logic                 eject_yneg_valid;
    logic                 eject_zneg_valid;
    logic [FLIT_SIZE-1:0] out_flit;
    logic                 out_valid;
    logic                 out_ready;
    logic [2:0]           out_port;
    logic [5:0]           overflow;
`ifdef EJECT_COLLECTOR_DROP_CNT_EN
    logic [15:0]          drop_count;
`endif

    modport slave (
        input  eject_xpos, eject_ypos, eject_zpos, eject_xneg, eject_yneg, eject_zneg,
        input  eject_xpos_valid, eject_ypos_valid, eject_zpos_valid,
        input  eject_xneg_valid, eject_yneg_valid, eject_zneg_valid,
        input  out_ready,
        output out_flit, out_valid, out_port, overflow
`ifdef EJECT_COLLECTOR_DROP_CNT_EN
        , output drop_count
`endif
    );

    modport master (
        output eject_xpos, eject_ypos, eject_zpos, eject_xneg, eject_yneg, eject_zneg,
        output eject_xpos_valid, eject_ypos_valid, eject_zpos_valid,
        output eject_xneg_valid, eject_yneg_valid, eject_zneg_valid,
        output out_ready,
        input  out_flit, out_valid, out_port, overflow
`ifdef EJECT_COLLECTOR_DROP_CNT_EN
        , input drop_count
`endif
    );
endinterface

// File: rtl/eject_collector.sv
// Ejection collector: six per-port FIFOs fed by the router (no backpressure),
// a round-robin arbiter over non-empty FIFOs and a single output register with
// valid/ready handshake. Full FIFOs drop incoming flits and set a sticky flag.
// Optional feature macro: EJECT_COLLECTOR_DROP_CNT_EN adds a saturating 16-bit
// drop_count output.
module eject_collector #(
    parameter int FLIT_SIZE  = 82,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    eject_collector_if.slave   bus
);
    localparam int NP = 6;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FLIT_SIZE-1:0] w_in_flit [NP];
    logic [NP-1:0]        w_in_valid;
    logic [FLIT_SIZE-1:0] w_head [NP];
    logic [NP-1:0]        w_empty;
    logic [NP-1:0]        w_drop;
    logic [NP-1:0]        w_grant_oh;
    logic [2:0]           w_grant_idx;
    logic                 w_found;
    logic                 w_load;

    logic [FLIT_SIZE-1:0] r_out_flit;
    logic [2:0]           r_out_port;
    logic                 r_out_valid;
    logic [2:0]           r_rr;
    logic [NP-1:0]        r_overflow;

    assign w_in_flit[0] = bus.eject_xpos;
    assign w_in_flit[1] = bus.eject_ypos;
    assign w_in_flit[2] = bus.eject_zpos;
    assign w_in_flit[3] = bus.eject_xneg;
    assign w_in_flit[4] = bus.eject_yneg;
    assign w_in_flit[5] = bus.eject_zneg;
    assign w_in_valid   = {bus.eject_zneg_valid, bus.eject_yneg_valid, bus.eject_xneg_valid,
                           bus.eject_zpos_valid, bus.eject_ypos_valid, bus.eject_xpos_valid};

    // The output register accepts a new flit when it is empty or being consumed.
    assign w_load = (!r_out_valid || bus.out_ready) && w_found;

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_port
            logic [FLIT_SIZE-1:0] r_mem [FIFO_DEPTH];
            logic [AW:0]          r_wr_ptr;
            logic [AW:0]          r_rd_ptr;
            logic                 w_full;
            logic                 w_wr;
            logic                 w_rd;

            // Extra pointer bit distinguishes full from empty. Fullness is the
            // pre-pop state, so a full FIFO drops even when it pops this cycle.
            assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
            assign w_empty[gi] = (r_wr_ptr == r_rd_ptr);
            assign w_wr        = w_in_valid[gi] && !w_full;
            assign w_rd        = w_load && w_grant_oh[gi];
            assign w_drop[gi]  = w_in_valid[gi] && w_full && !rst;
            // Head is read combinationally so a flit can reach the output
            // register in the cycle after it was written.
            assign w_head[gi]  = r_mem[r_rd_ptr[AW-1:0]];

            // Pointer and storage update; reset empties the FIFO and ignores input.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_wr) begin
                        r_mem[r_wr_ptr[AW-1:0]] <= w_in_flit[gi];
                        r_wr_ptr                <= r_wr_ptr + 1'b1;
                    end
                    if (w_rd) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
            end
        end
    endgenerate

    function automatic logic [2:0] f_wrap(input logic [2:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NP) s = s - NP;
        return 3'(s);
    endfunction

    // Round-robin search: first non-empty FIFO starting at r_rr, wrapping 5->0.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = 3'd0;
        w_grant_oh  = '0;
        for (int k = 0; k < NP; k++) begin
            if (!w_found && !w_empty[f_wrap(r_rr, k)]) begin
                w_found                       = 1'b1;
                w_grant_idx                   = f_wrap(r_rr, k);
                w_grant_oh[f_wrap(r_rr, k)]   = 1'b1;
            end
        end
    end

    // Output register and round-robin pointer; the pointer moves past the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_flit  <= '0;
            r_out_port  <= 3'd0;
            r_out_valid <= 1'b0;
            r_rr        <= 3'd0;
        end else if (w_load) begin
            r_out_flit  <= w_head[w_grant_idx];
            r_out_port  <= w_grant_idx;
            r_out_valid <= 1'b1;
            r_rr        <= (w_grant_idx == 3'd5) ? 3'd0 : w_grant_idx + 3'd1;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky per-port drop flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= '0;
        end else begin
            r_overflow <= r_overflow | w_drop;
        end
    end

    assign bus.out_flit  = r_out_flit;
    assign bus.out_port  = r_out_port;
    assign bus.out_valid = r_out_valid;
    assign bus.overflow  = r_overflow;

`ifdef EJECT_COLLECTOR_DROP_CNT_EN
    logic [15:0] r_drop_count;
    logic [2:0]  w_drop_num;
    logic [16:0] w_drop_sum;

    // Number of flits dropped this cycle across all ports.
    always_comb begin
        w_drop_num = 3'd0;
        for (int i = 0; i < NP; i++) begin
            w_drop_num = w_drop_num + 3'(w_drop[i]);
        end
    end

    assign w_drop_sum = {1'b0, r_drop_count} + {14'd0, w_drop_num};

    // Saturating accumulation of dropped flits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_count <= 16'd0;
        end else if (|w_drop) begin
            r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    assign bus.drop_count = r_drop_count;
`endif
endmodule

// File: tb/tb_eject_collector.sv
// Bench for eject_collector: table-driven handshake/arbitration vectors,
// directed multi-cycle sequences and randomized traffic against a queue-based
// reference model. Drop-counter checks are compiled when
// EJECT_COLLECTOR_DROP_CNT_EN is defined.
module tb_eject_collector;
    localparam int FW    = 82;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eject_collector_if #(.FLIT_SIZE(FW)) bus ();

    eject_collector #(.FLIT_SIZE(FW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [FW-1:0] in_f [6];

    // Reference model state: one queue per port, output register, pointer.
    logic [FW-1:0] mq [6][$];
    logic          mv;
    logic [FW-1:0] mflit;
    int            mport;
    int            mrr;
    logic [5:0]    movf;
    int            mdc;

    typedef struct {
        logic [5:0] vm;
        logic       rdy;
        logic       ev;
        logic [2:0] ep;
        logic [7:0] ef;
        logic [5:0] eovf;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic [5:0] vm, input logic rdy, input logic rs);
        logic [5:0] full;
        int drops;
        int idx;
        if (rs) begin
            for (int i = 0; i < 6; i++) mq[i].delete();
            mv = 1'b0; mflit = '0; mport = 0; mrr = 0; movf = '0; mdc = 0;
            return;
        end
        for (int i = 0; i < 6; i++) full[i] = (mq[i].size() == DEPTH);
        if (!mv || rdy) begin
            mv = 1'b0;
            for (int k = 0; k < 6; k++) begin
                idx = (mrr + k) % 6;
                if (!mv && mq[idx].size() > 0) begin
                    mv    = 1'b1;
                    mflit = mq[idx].pop_front();
                    mport = idx;
                end
            end
            if (mv && mport == ((mrr + 6) % 6) - 0 && 0) mrr = mrr;
            if (mv) mrr = (mport + 1) % 6;
        end
        drops = 0;
        for (int i = 0; i < 6; i++) begin
            if (vm[i]) begin
                if (full[i]) begin
                    movf[i] = 1'b1;
                    drops++;
                end else begin
                    mq[i].push_back(in_f[i]);
                end
            end
        end
        if (drops > 0) mdc = (mdc + drops > 65535) ? 65535 : mdc + drops;
    endtask

    task automatic compare_model();
        chk("m_out_valid", FW'(bus.out_valid), FW'(mv));
        if (mv) begin
            chk("m_out_flit", bus.out_flit, mflit);
            chk("m_out_port", FW'(bus.out_port), FW'(mport));
        end
        chk("m_overflow", FW'(bus.overflow), FW'(movf));
`ifdef EJECT_COLLECTOR_DROP_CNT_EN
        chk("m_drop_count", FW'(bus.drop_count), FW'(mdc));
`endif
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
    task automatic step(input logic [5:0] vm, input logic rdy, input logic rs);
        bus.eject_xpos = in_f[0];
        bus.eject_ypos = in_f[1];
        bus.eject_zpos = in_f[2];
        bus.eject_xneg = in_f[3];
        bus.eject_yneg = in_f[4];
        bus.eject_zneg = in_f[5];
        bus.eject_xpos_valid = vm[0];
        bus.eject_ypos_valid = vm[1];
        bus.eject_zpos_valid = vm[2];
        bus.eject_xneg_valid = vm[3];
        bus.eject_yneg_valid = vm[4];
        bus.eject_zneg_valid = vm[5];
        bus.out_ready = rdy;
        rst = rs;
        @(posedge clk);
        model_update(vm, rdy, rs);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        step(6'h00, 1'b0, 1'b1);
        chk("rst_out_valid", FW'(bus.out_valid), '0);
        chk("rst_out_flit", bus.out_flit, '0);
        chk("rst_out_port", FW'(bus.out_port), '0);
        chk("rst_overflow", FW'(bus.overflow), '0);
`ifdef EJECT_COLLECTOR_DROP_CNT_EN
        chk("rst_drop_count", FW'(bus.drop_count), '0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 6; i++) in_f[i] = '0;
        rst = 1'b1;
        do_reset();
        do_reset();

        // Latency: zpos flit in cycle 5 after reset appears two cycles later.
        for (int c = 0; c < 4; c++) step(6'h00, 1'b1, 1'b0);
        in_f[2] = FW'(1);
        step(6'h04, 1'b1, 1'b0);
        chk("lat_n1_valid", FW'(bus.out_valid), '0);
        step(6'h00, 1'b1, 1'b0);
        chk("lat_n2_valid", FW'(bus.out_valid), FW'(1));
        chk("lat_n2_flit", bus.out_flit, FW'(1));
        chk("lat_n2_port", FW'(bus.out_port), FW'(2));

        // Table: all six ports, a stall, then xpos+yneg.
        tbl[0]  = '{6'h3F, 1'b1, 1'b0, 3'd0, 8'h00, 6'h00};
        tbl[1]  = '{6'h00, 1'b1, 1'b1, 3'd0, 8'h10, 6'h00};
        tbl[2]  = '{6'h00, 1'b1, 1'b1, 3'd1, 8'h11, 6'h00};
        tbl[3]  = '{6'h00, 1'b0, 1'b1, 3'd1, 8'h11, 6'h00};
        tbl[4]  = '{6'h00, 1'b1, 1'b1, 3'd2, 8'h12, 6'h00};
        tbl[5]  = '{6'h00, 1'b1, 1'b1, 3'd3, 8'h13, 6'h00};
        tbl[6]  = '{6'h00, 1'b1, 1'b1, 3'd4, 8'h14, 6'h00};
        tbl[7]  = '{6'h11, 1'b1, 1'b1, 3'd5, 8'h15, 6'h00};
        tbl[8]  = '{6'h00, 1'b1, 1'b1, 3'd0, 8'h80, 6'h00};
        tbl[9]  = '{6'h00, 1'b1, 1'b1, 3'd4, 8'h84, 6'h00};
        tbl[10] = '{6'h00, 1'b1, 1'b0, 3'd0, 8'h00, 6'h00};
        do_reset();
        for (int r = 0; r < 11; r++) begin
            for (int i = 0; i < 6; i++) in_f[i] = FW'(((r + 1) << 4) | i);
            step(tbl[r].vm, tbl[r].rdy, 1'b0);
            chk($sformatf("tbl%0d_valid", r), FW'(bus.out_valid), FW'(tbl[r].ev));
            if (tbl[r].ev) begin
                chk($sformatf("tbl%0d_port", r), FW'(bus.out_port), FW'(tbl[r].ep));
                chk($sformatf("tbl%0d_flit", r), bus.out_flit, FW'(tbl[r].ef));
            end
            chk($sformatf("tbl%0d_ovf", r), FW'(bus.overflow), FW'(tbl[r].eovf));
        end

        // Single-port overflow with a stalled consumer, then drain in order.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            in_f[0] = FW'(k);
            step(6'h01, 1'b0, 1'b0);
        end
        chk("ovf1_hold_valid", FW'(bus.out_valid), FW'(1));
        chk("ovf1_hold_flit", bus.out_flit, FW'(1));
        chk("ovf1_flags", FW'(bus.overflow), FW'(6'b000001));
`ifdef EJECT_COLLECTOR_DROP_CNT_EN
        chk("ovf1_drop_count", FW'(bus.drop_count), FW'(1));
`endif
        for (int k = 2; k <= 5; k++) begin
            step(6'h00, 1'b1, 1'b0);
            chk($sformatf("drain%0d_flit", k), bus.out_flit, FW'(k));
            chk($sformatf("drain%0d_port", k), FW'(bus.out_port), '0);
        end
        step(6'h00, 1'b1, 1'b0);
        chk("drain_end_valid", FW'(bus.out_valid), '0);

        // Reset mid-transfer with three flits buffered and the output full.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            in_f[0] = FW'(k);
            step(6'h01, 1'b0, 1'b0);
        end
        chk("mid_pre_valid", FW'(bus.out_valid), FW'(1));
        step(6'h3F, 1'b1, 1'b1);
        chk("mid_rst_valid", FW'(bus.out_valid), '0);
        chk("mid_rst_ovf", FW'(bus.overflow), '0);
        for (int c = 0; c < 5; c++) begin
            step(6'h00, 1'b1, 1'b0);
            chk("mid_after_valid", FW'(bus.out_valid), '0);
        end

        // Back-to-back zneg stream.
        do_reset();
        for (int k = 1; k <= 21; k++) begin
            in_f[5] = FW'(k);
            step((k <= 20) ? 6'h20 : 6'h00, 1'b1, 1'b0);
            if (k == 1) begin
                chk("b2b_first_valid", FW'(bus.out_valid), '0);
            end else begin
                chk("b2b_valid", FW'(bus.out_valid), FW'(1));
                chk("b2b_flit", bus.out_flit, FW'(k - 1));
                chk("b2b_port", FW'(bus.out_port), FW'(5));
            end
        end
        step(6'h00, 1'b1, 1'b0);
        chk("b2b_end_valid", FW'(bus.out_valid), '0);
        chk("b2b_ovf", FW'(bus.overflow), '0);

        // All six ports overflowing, with a stalled consumer.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            for (int i = 0; i < 6; i++) in_f[i] = FW'((k << 4) | i);
            step(6'h3F, 1'b0, 1'b0);
`ifdef EJECT_COLLECTOR_DROP_CNT_EN
            if (k == 5) chk("six_dc_c5", FW'(bus.drop_count), FW'(5));
            if (k == 6) chk("six_dc_c6", FW'(bus.drop_count), FW'(11));
`endif
        end
        chk("six_ovf", FW'(bus.overflow), FW'(6'h3F));
`ifdef EJECT_COLLECTOR_DROP_CNT_EN
        for (int c = 0; c < 10920; c++) step(6'h3F, 1'b0, 1'b0);
        step(6'h07, 1'b0, 1'b0);
        chk("sat_fffe", FW'(bus.drop_count), FW'(16'hFFFE));
        step(6'h01, 1'b0, 1'b0);
        chk("sat_ffff", FW'(bus.drop_count), FW'(16'hFFFF));
        step(6'h3F, 1'b0, 1'b0);
        chk("sat_hold", FW'(bus.drop_count), FW'(16'hFFFF));
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [5:0] vm;
            logic       rdy;
            logic       rs;
            for (int i = 0; i < 6; i++) begin
                vm[i]   = ($urandom_range(0, 99) < 30);
                in_f[i] = FW'({$urandom(), $urandom(), $urandom()});
            end
            rdy = ((c / 50) % 3 == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
            rs  = ($urandom_range(0, 299) == 0);
            step(vm, rdy, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
